// File: rtl/joy_pkg.sv
// Shared types and pin/button maps for the joypad scanner.
// Holds the scan FSM states, NES bit order, Genesis pin order and the pad decoder.
`timescale 1ns/1ps
package joy_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL_HI,
        S_SAMPLE_HI,
        S_SEL_LO,
        S_SAMPLE_LO,
        S_COMMIT
    } scan_state_t;

    // NES button byte order
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // Genesis pins, select high
    localparam int GEN_UP    = 0;
    localparam int GEN_DOWN  = 1;
    localparam int GEN_LEFT  = 2;
    localparam int GEN_RIGHT = 3;
    localparam int GEN_B     = 4;
    localparam int GEN_C     = 5;
    // Genesis pins, select low
    localparam int GEN_DET0  = 2;
    localparam int GEN_DET1  = 3;
    localparam int GEN_A     = 4;
    localparam int GEN_START = 5;

    // Active-low pins to active-high NES byte; opposing directions cancel.
    function automatic logic [7:0] decode_pad(
        input logic [5:0] hi,
        input logic [5:2] lo
    );
        logic [7:0] c;
        c             = '0;
        c[BTN_A]      = ~hi[GEN_B];
        c[BTN_B]      = ~lo[GEN_A];
        c[BTN_SELECT] = ~hi[GEN_C];
        c[BTN_START]  = ~lo[GEN_START];
        c[BTN_UP]     = ~hi[GEN_UP];
        c[BTN_DOWN]   = ~hi[GEN_DOWN];
        c[BTN_LEFT]   = ~hi[GEN_LEFT];
        c[BTN_RIGHT]  = ~hi[GEN_RIGHT];
        if (c[BTN_UP] && c[BTN_DOWN]) begin
            c[BTN_UP]   = 1'b0;
            c[BTN_DOWN] = 1'b0;
        end
        if (c[BTN_LEFT] && c[BTN_RIGHT]) begin
            c[BTN_LEFT]  = 1'b0;
            c[BTN_RIGHT] = 1'b0;
        end
        return c;
    endfunction

endpackage

// File: rtl/joy_pad_port.sv
// One joypad port: pin synchroniser, phase capture, decode, debounce, hold deferral.
// Ports: clk_i/rst_i, pins_i raw pins, strobes from the scan FSM, hold_i; state/present/done out.
`timescale 1ns/1ps
module joy_pad_port
    import joy_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] pins_i,
    input  logic       hold_i,
    input  logic       sample_hi_i,
    input  logic       sample_lo_i,
    input  logic       commit_i,
    output logic [7:0] state_o,
    output logic       present_o,
    output logic       done_o
);

    logic [5:0] meta_q, sync_q, hi_q;
    logic [5:2] lo_q;
    logic [7:0] prev_q, state_q, pend_state_q;
    logic       present_q, pend_present_q, pend_q, done_q;

    logic       present_d;
    logic [7:0] cand_d, base_d, state_d;

    always_comb begin
        present_d = ~lo_q[GEN_DET0] & ~lo_q[GEN_DET1];
        cand_d    = present_d ? decode_pad(hi_q, lo_q) : 8'h00;
        // A value already waiting behind hold is the newest accepted state.
        base_d    = pend_q ? pend_state_q : state_q;
        state_d   = (cand_d == prev_q) ? cand_d : base_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q         <= '0;
            sync_q         <= '0;
            hi_q           <= '0;
            lo_q           <= '0;
            prev_q         <= '0;
            state_q        <= '0;
            pend_state_q   <= '0;
            present_q      <= 1'b0;
            pend_present_q <= 1'b0;
            pend_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            meta_q <= pins_i;
            sync_q <= meta_q;
            done_q <= 1'b0;
            if (sample_hi_i) hi_q <= sync_q;
            if (sample_lo_i) lo_q <= sync_q[5:2];
            if (commit_i) begin
                prev_q <= cand_d;
                if (hold_i) begin
                    pend_q         <= 1'b1;
                    pend_state_q   <= state_d;
                    pend_present_q <= present_d;
                end else begin
                    state_q   <= state_d;
                    present_q <= present_d;
                    pend_q    <= 1'b0;
                    done_q    <= 1'b1;
                end
            end else if (pend_q && !hold_i) begin
                state_q   <= pend_state_q;
                present_q <= pend_present_q;
                pend_q    <= 1'b0;
                done_q    <= 1'b1;
            end
        end
    end

    assign state_o   = state_q;
    assign present_o = present_q;
    assign done_o    = done_q;

endmodule

// File: rtl/joy_pad_scanner.sv
// Joypad scan sequencer: shared select FSM and counters driving two pad ports.
// Ports: I_clock, I_reset, I_GPIO_state, I_hold in; O_joy_select, O_pad_state, O_pad_present, O_scan_done out.
`timescale 1ns/1ps
module joy_pad_scanner
    import joy_pkg::*;
#(
    parameter int SETTLE_CYCLES = 64,
    parameter int SCAN_PERIOD   = 16384
) (
    input  logic            I_clock,
    input  logic            I_reset,
    input  logic [1:0][5:0] I_GPIO_state,
    input  logic            I_hold,
    output logic [1:0]      O_joy_select,
    output logic [1:0][7:0] O_pad_state,
    output logic [1:0]      O_pad_present,
    output logic            O_scan_done
);

    localparam int PW = $clog2(SCAN_PERIOD);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    scan_state_t state_q, state_d;
    logic [PW-1:0] per_q, per_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic per_wrap, settled;
    logic sel, smp_hi, smp_lo, commit;
    logic [1:0] done;

    assign per_wrap = (per_q == PW'(SCAN_PERIOD - 1));
    assign settled  = (cnt_q == SW'(SETTLE_CYCLES - 1));
    assign per_d    = per_wrap ? '0 : per_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        sel     = 1'b1;
        smp_hi  = 1'b0;
        smp_lo  = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (per_wrap) state_d = S_SEL_HI;
            end
            S_SEL_HI: begin
                if (settled) state_d = S_SAMPLE_HI;
                else         cnt_d   = cnt_q + 1'b1;
            end
            S_SAMPLE_HI: begin
                smp_hi  = 1'b1;
                state_d = S_SEL_LO;
            end
            S_SEL_LO: begin
                sel = 1'b0;
                if (settled) state_d = S_SAMPLE_LO;
                else         cnt_d   = cnt_q + 1'b1;
            end
            S_SAMPLE_LO: begin
                sel     = 1'b0;
                smp_lo  = 1'b1;
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                commit  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            state_q <= S_IDLE;
            per_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_port
        joy_pad_port u_port (
            .clk_i       (I_clock),
            .rst_i       (I_reset),
            .pins_i      (I_GPIO_state[g]),
            .hold_i      (I_hold),
            .sample_hi_i (smp_hi),
            .sample_lo_i (smp_lo),
            .commit_i    (commit),
            .state_o     (O_pad_state[g]),
            .present_o   (O_pad_present[g]),
            .done_o      (done[g])
        );
    end

    assign O_joy_select = {sel, sel};
    assign O_scan_done  = |done;

endmodule
